// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Write-back arbiter and scoreboard in front of an 8x8 register
//            file. Two requesters (A = ALU result, B = load/immediate) share
//            the file's single write port under round-robin arbitration. A
//            per-register busy bit tells decode to stall on operands whose
//            producing write has not committed yet.
// Ports    : CLK, RESET           - clock, synchronous active-high reset
//            A_VALID/ADDR/DATA    - requester A write request
//            A_READY              - requester A granted this cycle
//            B_VALID/ADDR/DATA    - requester B write request
//            B_READY              - requester B granted this cycle
//            ISSUE, ISSUE_DEST    - issue of an instruction with a destination
//            RD1ADDR, RD2ADDR     - decode source registers
//            STALL                - a decode source is busy
//            WRITE/INADDRESS/IN   - registered register-file write port
//            BUSY                 - scoreboard, one bit per register
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A_VALID,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_READY,
  input  logic              B_VALID,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_READY,
  input  logic              ISSUE,
  input  logic [ADDR_W-1:0] ISSUE_DEST,
  input  logic [ADDR_W-1:0] RD1ADDR,
  input  logic [ADDR_W-1:0] RD2ADDR,
  output logic              STALL,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN,
  output logic [NREG-1:0]   BUSY
);

  localparam logic c_PTR_A = 1'b0;
  localparam logic c_PTR_B = 1'b1;

  logic              ptr_q, ptr_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              w_a_grant;
  logic              w_b_grant;

  // The pointer only matters when both sides contend; a lone requester is
  // always granted. Reset suppresses both grants so nothing transfers.
  always_comb begin
    w_a_grant = 1'b0;
    w_b_grant = 1'b0;
    if (!RESET) begin
      w_a_grant = A_VALID && (!B_VALID || (ptr_q == c_PTR_A));
      w_b_grant = B_VALID && (!A_VALID || (ptr_q == c_PTR_B));
    end
  end

  assign A_READY = w_a_grant;
  assign B_READY = w_b_grant;

  always_comb begin
    ptr_d   = ptr_q;
    write_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;

    if (w_a_grant) begin
      ptr_d           = c_PTR_B;
      write_d         = 1'b1;
      waddr_d         = A_ADDR;
      wdata_d         = A_DATA;
      busy_d[A_ADDR]  = 1'b0;
    end else if (w_b_grant) begin
      ptr_d           = c_PTR_A;
      write_d         = 1'b1;
      waddr_d         = B_ADDR;
      wdata_d         = B_DATA;
      busy_d[B_ADDR]  = 1'b0;
    end

    // Set is applied after the clear so a new producer issued on the same
    // edge as the old producer's write-back keeps the register busy.
    if (ISSUE) begin
      busy_d[ISSUE_DEST] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q   <= c_PTR_A;
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign WRITE     = write_q;
  assign INADDRESS = waddr_q;
  assign IN        = wdata_q;
  assign BUSY      = busy_q;
  assign STALL     = busy_q[RD1ADDR] | busy_q[RD2ADDR];

endmodule
`default_nettype wire
